mac_tile_mm: RTL and testbench

MAC_TILE_MM -- requirements
Module: mac_tile_mm

---
 rtl/mac_tile_mm.sv | 160 ++++++++++++++++
 tb/tb_mac_tile_mm.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mac_tile_mm.sv
// mac_tile_mm: systolic MAC tile supporting weight-stationary (WS) and
// output-stationary (OS) dataflows. Optional build macro MAC_TILE_SAT_EN
// enables signed saturation of the WS sum and the OS accumulator;
// without it both wrap modulo 2^psum_bw.
module mac_tile_mm #(
    parameter int bw      = 4,
    parameter int psum_bw = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mode_select,
    input  logic [bw-1:0]      in_w,
    input  logic [2:0]         inst_w,
    input  logic [psum_bw-1:0] in_n,
    output logic [bw-1:0]      out_e,
    output logic [2:0]         inst_e,
    output logic [psum_bw-1:0] out_s,
    output logic               out_s_valid,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, WS_RUN, OS_RUN, OS_DRAIN} state_t;

    state_t               state_q, state_d;
    logic [bw-1:0]        a_q, a_d, b_q, b_d;
    logic [psum_bw-1:0]   c_q, c_d, acc_q, acc_d, out_s_q, out_s_d;
    logic                 exec_q, exec_d, load_ready_q, load_ready_d;
    logic                 valid_q, valid_d;
    logic [2:0]           inst_e_q, inst_e_d;

    logic signed [2*bw:0] a_ext, b_ext, prod_raw;
    logic [psum_bw-1:0]   prod, ws_sum, os_sum;
    logic                 ws_mode;

    // Two's-complement add of psum values; clamps to the signed range when saturation is built in
    function automatic logic [psum_bw-1:0] add_ps(input logic [psum_bw-1:0] x,
                                                  input logic [psum_bw-1:0] y);
        logic [psum_bw-1:0] s;
        s = x + y;
`ifdef MAC_TILE_SAT_EN
        if ((x[psum_bw-1] == y[psum_bw-1]) && (s[psum_bw-1] != x[psum_bw-1]))
            s = x[psum_bw-1] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
`endif
        return s;
    endfunction

    // Unsigned activation times signed weight, sign-extended to psum width
    always_comb begin
        a_ext    = {{bw{1'b0}}, a_q};
        b_ext    = {{(bw+1){b_q[bw-1]}}, b_q};
        prod_raw = a_ext * b_ext;
        prod     = psum_bw'(prod_raw);
        ws_sum   = add_ps(prod, c_q);
        os_sum   = add_ps(acc_q, exec_q ? prod : '0);
    end

    // Next-state logic; IDLE already performs the first operation of the mode it is leaving for
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        c_d          = in_n;
        acc_d        = acc_q;
        out_s_d      = out_s_q;
        exec_d       = 1'b0;
        load_ready_d = load_ready_q;
        valid_d      = 1'b0;
        inst_e_d     = inst_w;

        ws_mode = (state_q == WS_RUN) || ((state_q == IDLE) && !mode_select);

        if (ws_mode) begin
            if (inst_w[1] || inst_w[0])
                a_d = in_w;
            if (inst_w[0] && load_ready_q) begin
                b_d          = in_w;
                load_ready_d = 1'b0;
            end
            inst_e_d = {inst_w[2:1], inst_w[0] & ~load_ready_q};
        end

        case (state_q)
            IDLE: begin
                if (!mode_select) begin
                    if (inst_w[1:0] != 2'b00)
                        state_d = WS_RUN;
                end else if (inst_w[1]) begin
                    a_d     = in_w;
                    b_d     = in_n[bw-1:0];
                    exec_d  = 1'b1;
                    out_s_d = psum_bw'($signed(in_n[bw-1:0]));
                    state_d = OS_RUN;
                end
            end
            WS_RUN: begin
                if (inst_w == 3'b000)
                    state_d = IDLE;
            end
            OS_RUN: begin
                acc_d = os_sum;
                if (inst_w[2]) begin
                    out_s_d = os_sum;
                    valid_d = 1'b1;
                    state_d = OS_DRAIN;
                end else if (inst_w[1]) begin
                    a_d     = in_w;
                    b_d     = in_n[bw-1:0];
                    exec_d  = 1'b1;
                    out_s_d = psum_bw'($signed(in_n[bw-1:0]));
                end else if (inst_w == 3'b000) begin
                    state_d = IDLE;
                end
            end
            OS_DRAIN: begin
                if (inst_w[2]) begin
                    out_s_d = in_n;
                    valid_d = 1'b1;
                end else begin
                    acc_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            c_q          <= '0;
            acc_q        <= '0;
            out_s_q      <= '0;
            exec_q       <= 1'b0;
            load_ready_q <= 1'b1;
            valid_q      <= 1'b0;
            inst_e_q     <= '0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            c_q          <= c_d;
            acc_q        <= acc_d;
            out_s_q      <= out_s_d;
            exec_q       <= exec_d;
            load_ready_q <= load_ready_d;
            valid_q      <= valid_d;
            inst_e_q     <= inst_e_d;
        end
    end

    assign out_e       = a_q;
    assign inst_e      = inst_e_q;
    assign out_s_valid = valid_q;
    assign busy        = (state_q != IDLE);
    assign out_s       = ((state_q == OS_RUN) || (state_q == OS_DRAIN)) ? out_s_q : ws_sum;

endmodule

// File: tb/tb_mac_tile_mm.sv
// Directed self-checking bench for mac_tile_mm (bw=4, psum_bw=16).
module tb_mac_tile_mm;

    localparam int BW = 4;
    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          mode_select;
    logic [BW-1:0] in_w;
    logic [2:0]    inst_w;
    logic [PW-1:0] in_n;
    logic [BW-1:0] out_e;
    logic [2:0]    inst_e;
    logic [PW-1:0] out_s;
    logic          out_s_valid;
    logic          busy;

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] sat_exp;

    mac_tile_mm #(.bw(BW), .psum_bw(PW)) dut (
        .clk(clk), .reset(reset), .mode_select(mode_select), .in_w(in_w),
        .inst_w(inst_w), .in_n(in_n), .out_e(out_e), .inst_e(inst_e),
        .out_s(out_s), .out_s_valid(out_s_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; inst_w = 3'b000; in_w = '0; in_n = '0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; mode_select = 1'b0; in_w = '0; inst_w = 3'b000; in_n = '0;
        tick(); tick();
        chk("rst_out_s", 32'(out_s), 32'h0);
        chk("rst_valid", 32'(out_s_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_inst_e", 32'(inst_e), 32'h0);
        chk("rst_out_e", 32'(out_e), 32'h0);
        reset = 1'b0;

        // WS load of weight 3, then execute a=5 with psum 10
        mode_select = 1'b0; in_w = 4'd3; inst_w = 3'b001; in_n = 16'd0;
        tick();
        chk("ws_load_inst_e", 32'(inst_e), 32'h0);
        chk("ws_load_busy", 32'(busy), 32'h1);
        chk("ws_load_out_e", 32'(out_e), 32'h3);
        in_w = 4'd5; in_n = 16'd10; inst_w = 3'b010;
        tick();
        chk("ws_exec_out_s", 32'(out_s), 32'd25);
        chk("ws_exec_inst_e", 32'(inst_e), 32'b010);
        in_w = 4'd2; in_n = 16'd0; inst_w = 3'b001;
        tick();
        chk("ws_post_load_inst_e", 32'(inst_e), 32'b001);
        chk("ws_post_load_out_s", 32'(out_s), 32'd6);
        inst_w = 3'b000;
        tick();
        chk("ws_idle_busy", 32'(busy), 32'h0);

        // WS signed weight -2
        do_reset();
        mode_select = 1'b0; in_w = 4'b1110; inst_w = 3'b001; in_n = 16'd0;
        tick();
        in_w = 4'd7; inst_w = 3'b010;
        tick();
        chk("ws_signed_out_s", 32'(out_s), 32'hFFF2);
        in_w = 4'd5; inst_w = 3'b001;
        tick();
        chk("ws_reload_ignored", 32'(out_s), 32'hFFF6);
        in_w = 4'd7; inst_w = 3'b010;
        tick();
        chk("ws_reload_ignored2", 32'(out_s), 32'hFFF2);
        inst_w = 3'b000;
        tick();

        // OS: 4 executes of 2*3, then drain
        do_reset();
        mode_select = 1'b1; in_w = 4'd2; in_n = 16'd3; inst_w = 3'b010;
        tick();
        chk("os_fwd_weight", 32'(out_s), 32'h3);
        chk("os_run_valid", 32'(out_s_valid), 32'h0);
        chk("os_run_inst_e", 32'(inst_e), 32'b010);
        tick(); tick(); tick();
        inst_w = 3'b100; in_n = 16'h1234;
        tick();
        chk("os_drain_out_s", 32'(out_s), 32'd24);
        chk("os_drain_valid", 32'(out_s_valid), 32'h1);
        in_n = 16'h00AB;
        tick();
        chk("os_pass_out_s", 32'(out_s), 32'h00AB);
        chk("os_pass_valid", 32'(out_s_valid), 32'h1);
        inst_w = 3'b000;
        tick();
        chk("os_exit_valid", 32'(out_s_valid), 32'h0);
        chk("os_exit_busy", 32'(busy), 32'h0);
        // accumulator must have been cleared: single 1*1 product drains as 1
        in_w = 4'd1; in_n = 16'd1; inst_w = 3'b010;
        tick();
        inst_w = 3'b100;
        tick();
        chk("os_acc_cleared", 32'(out_s), 32'd1);
        inst_w = 3'b000;
        tick();

        // Mode flip during OS_RUN is ignored; reset mid-drain
        mode_select = 1'b1; in_w = 4'd3; in_n = 16'h000E; inst_w = 3'b010;
        tick();
        chk("os_neg_weight_fwd", 32'(out_s), 32'hFFFE);
        mode_select = 1'b0;
        tick();
        chk("flip_busy", 32'(busy), 32'h1);
        chk("flip_out_s_os", 32'(out_s), 32'hFFFE);
        inst_w = 3'b100;
        tick();
        chk("flip_drain_out_s", 32'(out_s), 32'hFFF4);
        in_n = 16'h5555;
        tick();
        chk("flip_pass_out_s", 32'(out_s), 32'h5555);
        reset = 1'b1;
        tick();
        chk("mid_drain_rst_out_s", 32'(out_s), 32'h0);
        chk("mid_drain_rst_valid", 32'(out_s_valid), 32'h0);
        chk("mid_drain_rst_busy", 32'(busy), 32'h0);
        chk("mid_drain_rst_inst_e", 32'(inst_e), 32'h0);
        chk("mid_drain_rst_out_e", 32'(out_e), 32'h0);
        reset = 1'b0; inst_w = 3'b000;
        tick();

        // Long accumulation 400 x (15*7)
`ifdef MAC_TILE_SAT_EN
        sat_exp = 16'h7FFF;
`else
        sat_exp = 16'hA410;
`endif
        mode_select = 1'b1; in_w = 4'd15; in_n = 16'd7; inst_w = 3'b010;
        for (int i = 0; i < 400; i++) tick();
        inst_w = 3'b100;
        tick();
        chk("long_acc_out_s", 32'(out_s), 32'(sat_exp));
        inst_w = 3'b000;
        tick();
        chk("long_acc_idle", 32'(busy), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
